// File: rtl/global_io_sacc.sv
// rtl/global_io_sacc.sv - bit-serial shift-accumulator merging DCIM column-segment MAC outputs
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   macout       NSEG packed segment MAC outputs, segment k = macout[k*MAC_W +: MAC_W]
//   wmode        merged segments minus one, latched on st
//   in_bits      input precision in cycles (0 or too large means MAX_IN_BITS), latched on st
//   signed_in    first (MSB) bit plane weighs negative, latched on st
//   st           start pulse, also aborts and restarts a running sequence
//   acm_en       macout holds a valid bit-plane result this cycle
//   nout         registered two's-complement result, held until the next completion
//   nout_valid   one-cycle pulse when nout updates
//   busy         accumulation in progress
module global_io_sacc #(
    parameter int MAC_W       = 15,
    parameter int NSEG        = 2,
    parameter int SEG_SHIFT   = 12,
    parameter int MAX_IN_BITS = 8,
    parameter int OUT_W       = 51,
    localparam int WM_W       = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSEG*MAC_W-1:0] macout,
    input  logic [WM_W-1:0]       wmode,
    input  logic [3:0]            in_bits,
    input  logic                  signed_in,
    input  logic                  st,
    input  logic                  acm_en,
    output logic [OUT_W-1:0]      nout,
    output logic                  nout_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [WM_W-1:0] WM_MAX = WM_W'(NSEG - 1);
    localparam logic [3:0]      IB_MAX = 4'(MAX_IN_BITS);

    state_t            state, state_n;
    logic [WM_W-1:0]   wmode_q;
    logic [3:0]        in_bits_q;
    logic              signed_q;
    logic [3:0]        cnt;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  sel;
    logic [OUT_W-1:0]  acc_next;
    logic              accept;
    logic              last;
    logic [WM_W-1:0]   wmode_c;
    logic [3:0]        in_bits_c;

    // Clamp configuration before latching so the datapath only sees legal values.
    assign wmode_c   = (wmode > WM_MAX) ? WM_MAX : wmode;
    assign in_bits_c = (in_bits == 4'd0 || in_bits > IB_MAX) ? IB_MAX : in_bits;

    // Merge the enabled segments; segments above wmode_q contribute nothing.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (k <= int'(wmode_q))
                sel = sel + (OUT_W'(macout[k*MAC_W +: MAC_W]) << (k * SEG_SHIFT));
        end
    end

    // st takes priority over a coincident acm_en, so that bit plane is dropped.
    assign accept   = (state == ACC) && !st && acm_en;
    assign last     = accept && (cnt == in_bits_q - 4'd1);
    // The MSB plane of a signed input carries negative weight.
    assign acc_next = (signed_q && cnt == 4'd0) ? ((acc << 1) - sel) : ((acc << 1) + sel);
    assign busy     = (state == ACC);

    always_comb begin
        state_n = state;
        if (st) begin
            state_n = ACC;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                ACC:     if (last) state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wmode_q    <= '0;
            in_bits_q  <= IB_MAX;
            signed_q   <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            nout       <= '0;
            nout_valid <= 1'b0;
        end else begin
            nout_valid <= last;
            if (st) begin
                wmode_q   <= wmode_c;
                in_bits_q <= in_bits_c;
                signed_q  <= signed_in;
                cnt       <= '0;
                acc       <= '0;
            end else if (accept) begin
                acc <= acc_next;
                cnt <= cnt + 4'd1;
                if (last) nout <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_global_io_sacc.sv
// tb/tb_global_io_sacc.sv - self-checking bench for global_io_sacc
module tb_global_io_sacc;

    localparam int MAC_W = 15;
    localparam int NSEG  = 2;
    localparam int OUT_W = 51;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NSEG*MAC_W-1:0] macout = '0;
    logic [0:0]            wmode = '0;
    logic [3:0]            in_bits = 4'd0;
    logic                  signed_in = 1'b0;
    logic                  st = 1'b0;
    logic                  acm_en = 1'b0;
    logic [OUT_W-1:0]      nout;
    logic                  nout_valid;
    logic                  busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int p0;
    logic [OUT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    global_io_sacc #(
        .MAC_W(MAC_W), .NSEG(NSEG), .SEG_SHIFT(12), .MAX_IN_BITS(8), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .macout(macout), .wmode(wmode), .in_bits(in_bits),
        .signed_in(signed_in), .st(st), .acm_en(acm_en),
        .nout(nout), .nout_valid(nout_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: each nout_valid pulse consumes one expected result.
    always @(negedge clk) begin
        if (nout_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_valid", 64'(nout), 64'hFFFF_FFFF);
            else chk("nout", 64'(nout), 64'(exp_q.pop_front()));
        end
    end

    task automatic cyc(input logic s, input logic a, input int s0, input int s1);
        @(negedge clk);
        st     = s;
        acm_en = a;
        macout = {MAC_W'(s1), MAC_W'(s0)};
    endtask

    task automatic cfg(input logic [0:0] wm, input logic [3:0] ib, input logic sg);
        wmode = wm; in_bits = ib; signed_in = sg;
    endtask

    initial begin
        #1;
        chk("rst_nout", 64'(nout), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valid", 64'(nout_valid), 0);
        @(negedge clk); rst = 1'b0;

        // 1: single segment, unsigned, 3 bits; segment 1 must be ignored
        cfg(0, 3, 0); p0 = pulses;
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(110));
        cyc(0, 1, 10, 999); chk("t1_busy", 64'(busy), 1);
        cyc(0, 1, 20, 999);
        cyc(0, 1, 30, 999);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t1_busy_after", 64'(busy), 0);
        chk("t1_pulses", 64'(pulses - p0), 1);

        // 2a: two merged segments, one bit only -> value after the first bit
        cfg(1, 1, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(4106));
        cyc(0, 1, 10, 1);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        // 2b: two merged segments, two bits
        cfg(1, 2, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(16424));
        cyc(0, 1, 10, 1);
        cyc(0, 1, 20, 2);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        // 3: signed input, MSB plane negative
        cfg(0, 2, 1);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(-7));
        cyc(0, 1, 5, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t3_busy_after", 64'(busy), 0);

        // 4: stall between bit planes
        cfg(0, 2, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(205));
        cyc(0, 1, 100, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 77, 77);
            chk("t4_busy_stall", 64'(busy), 1);
        end
        cyc(0, 1, 5, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        // 5: restart after one bit; old result held until new completion
        cfg(0, 3, 0); p0 = pulses;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 7, 0);
        cyc(1, 1, 55, 0); exp_q.push_back(OUT_W'(396));
        cyc(0, 1, 99, 0);
        chk("t5_nout_held", 64'(nout), 205);
        chk("t5_busy", 64'(busy), 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("t5_nout_held2", 64'(nout), 205);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t5_pulses", 64'(pulses - p0), 1);

        // in_bits clamp: 0 and 9 both mean 8 bit planes
        cfg(0, 0, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(255));
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cfg(0, 9, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(32767 * 255));
        for (int i = 0; i < 8; i++) cyc(0, 1, 32767, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

        // 6: asynchronous reset mid-sequence
        cfg(0, 3, 0); p0 = pulses;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 1, 9, 0);
        rst = 1'b1;
        #1;
        chk("t6_nout", 64'(nout), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_valid", 64'(nout_valid), 0);
        cyc(0, 1, 9, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t6_no_pulse", 64'(pulses - p0), 0);
        cfg(0, 2, 0);
        cyc(1, 0, 0, 0); exp_q.push_back(OUT_W'(15));
        cyc(0, 1, 7, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        chk("t6_pulses", 64'(pulses - p0), 1);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
